// File: rtl/contour_tracer_seq.sv
// contour_tracer_seq: sequential contour tracer for a flattened multi-bit
// pixel frame. A raster scan finds the first foreground pixel, then the
// boundary is followed one neighbour test per cycle using either Moore
// 8-connected following (algo=0) or 4-connected square tracing (algo=1).
module contour_tracer_seq #(
  parameter int W         = 26,
  parameter int H         = 18,
  parameter int BPP       = 2,
  parameter int MAX_STEPS = 4 * W * H,
  parameter int LW        = $clog2(W * H + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 algo,
  input  logic [BPP-1:0]       fg_code,
  input  logic [W*H*BPP-1:0]   inp,
  output logic [W*H-1:0]       contour,
  output logic [LW-1:0]        contour_len,
  output logic                 busy,
  output logic                 done,
  output logic                 empty,
  output logic                 timeout
);

  localparam int NPIX = W * H;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  // Two spare bits: one for sign, one so W/H themselves stay representable.
  localparam int CW   = $clog2(((W > H) ? W : H) + 1) + 2;
  localparam int SW   = $clog2(MAX_STEPS + 1);

  localparam logic signed [CW-1:0] P1    = CW'(1);
  localparam logic signed [CW-1:0] M1    = -P1;
  localparam logic signed [CW-1:0] ZERO  = CW'(0);
  localparam logic signed [CW-1:0] WS    = CW'(W);
  localparam logic signed [CW-1:0] HS    = CW'(H);
  localparam logic signed [CW-1:0] WLAST = CW'(W - 1);
  localparam logic signed [CW-1:0] HLAST = CW'(H - 1);
  localparam logic [SW-1:0]        STEP_LIMIT = SW'(MAX_STEPS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_TRACE = 2'd2;

  logic [1:0]             state_q,   state_d;
  logic [W*H*BPP-1:0]     frame_q,   frame_d;
  logic                   algo_q,    algo_d;
  logic [BPP-1:0]         fg_q,      fg_d;
  logic signed [CW-1:0]   cx_q,      cx_d;
  logic signed [CW-1:0]   cy_q,      cy_d;
  logic signed [CW-1:0]   sx_q,      sx_d;
  logic signed [CW-1:0]   sy_q,      sy_d;
  logic [2:0]             dir_q,     dir_d;
  logic [2:0]             bgcnt_q,   bgcnt_d;
  logic [SW-1:0]          steps_q,   steps_d;
  logic [NPIX-1:0]        contour_q, contour_d;
  logic [LW-1:0]          len_q,     len_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;
  logic                   empty_q,   empty_d;
  logic                   timeout_q, timeout_d;

  logic signed [CW-1:0]   dx, dy, tx, ty;
  logic                   inFrame;
  logic [PW-1:0]          pixIdx, safeIdx;
  logic [BPP-1:0]         testPix;
  logic                   testFg, onStart, newBit;
  logic [SW-1:0]          stepsInc;
  logic                   stepLimit;

  // Locate the pixel under test this cycle: raster position while scanning,
  // neighbour of the current pixel in the search direction while tracing.
  always_comb begin
    dx = ZERO;
    dy = ZERO;
    if (state_q == ST_TRACE) begin
      case (dir_q)
        3'd0:    begin dx = P1;   dy = ZERO; end
        3'd1:    begin dx = P1;   dy = P1;   end
        3'd2:    begin dx = ZERO; dy = P1;   end
        3'd3:    begin dx = M1;   dy = P1;   end
        3'd4:    begin dx = M1;   dy = ZERO; end
        3'd5:    begin dx = M1;   dy = M1;   end
        3'd6:    begin dx = ZERO; dy = M1;   end
        default: begin dx = P1;   dy = M1;   end
      endcase
    end
    tx        = cx_q + dx;
    ty        = cy_q + dy;
    inFrame   = !tx[CW-1] && !ty[CW-1] && (tx < WS) && (ty < HS);
    pixIdx    = PW'(ty) * PW'(W) + PW'(tx);
    safeIdx   = inFrame ? pixIdx : '0;
    testPix   = frame_q[safeIdx*BPP +: BPP];
    testFg    = inFrame && (testPix == fg_q);
    onStart   = (tx == sx_q) && (ty == sy_q);
    newBit    = testFg && !contour_q[safeIdx];
    stepsInc  = (steps_q == STEP_LIMIT) ? steps_q : steps_q + SW'(1);
    stepLimit = (stepsInc == STEP_LIMIT);
  end

  // Next-state logic for the scan / trace controller and result registers.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    algo_d    = algo_q;
    fg_d      = fg_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    dir_d     = dir_q;
    bgcnt_d   = bgcnt_q;
    steps_d   = steps_q;
    contour_d = contour_q;
    len_d     = len_q;
    busy_d    = busy_q;
    done_d    = done_q;
    empty_d   = empty_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_d   = inp;
          algo_d    = algo;
          fg_d      = fg_code;
          contour_d = '0;
          len_d     = '0;
          done_d    = 1'b0;
          empty_d   = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          cx_d      = ZERO;
          cy_d      = ZERO;
          steps_d   = '0;
          bgcnt_d   = '0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (testFg) begin
          sx_d               = cx_q;
          sy_d               = cy_q;
          contour_d[safeIdx] = 1'b1;
          len_d              = LW'(1);
          dir_d              = algo_q ? 3'd6 : 3'd7;
          state_d            = ST_TRACE;
        end else if ((cx_q == WLAST) && (cy_q == HLAST)) begin
          done_d  = 1'b1;
          empty_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cx_q == WLAST) begin
          cx_d = ZERO;
          cy_d = cy_q + P1;
        end else begin
          cx_d = cx_q + P1;
        end
      end
      ST_TRACE: begin
        if (!algo_q) begin
          if (testFg) begin
            cx_d    = tx;
            cy_d    = ty;
            steps_d = stepsInc;
            bgcnt_d = '0;
            dir_d   = dir_q[0] ? dir_q + 3'd6 : dir_q + 3'd7;
            if (newBit) begin
              contour_d[safeIdx] = 1'b1;
              len_d              = len_q + LW'(1);
            end
            if (onStart) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else if (stepLimit) begin
              done_d    = 1'b1;
              timeout_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = ST_IDLE;
            end
          end else begin
            dir_d   = dir_q + 3'd1;
            bgcnt_d = bgcnt_q + 3'd1;
            if (bgcnt_q == 3'd7) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end else begin
          cx_d    = tx;
          cy_d    = ty;
          steps_d = stepsInc;
          if (onStart && (dir_q == 3'd0)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            if (testFg) begin
              dir_d = dir_q - 3'd2;
              if (newBit) begin
                contour_d[safeIdx] = 1'b1;
                len_d              = len_q + LW'(1);
              end
            end else begin
              dir_d = dir_q + 3'd2;
            end
            if (stepLimit) begin
              done_d    = 1'b1;
              timeout_d = 1'b1;
              busy_d    = 1'b0;
              state_d   = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      algo_q    <= 1'b0;
      fg_q      <= '0;
      cx_q      <= ZERO;
      cy_q      <= ZERO;
      sx_q      <= ZERO;
      sy_q      <= ZERO;
      dir_q     <= 3'd0;
      bgcnt_q   <= 3'd0;
      steps_q   <= '0;
      contour_q <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      empty_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      algo_q    <= algo_d;
      fg_q      <= fg_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      dir_q     <= dir_d;
      bgcnt_q   <= bgcnt_d;
      steps_q   <= steps_d;
      contour_q <= contour_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      empty_q   <= empty_d;
      timeout_q <= timeout_d;
    end
  end

  assign contour     = contour_q;
  assign contour_len = len_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign empty       = empty_q;
  assign timeout     = timeout_q;

endmodule
